// File: rtl/sm4_block_if.sv
// Word-stream wrapper for the SM4 round engine: packs four input words into a
// block, applies ECB/CBC chaining around the core, and serialises the result.
module sm4_block_if #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_en,
  input  logic             cbc_en,
  input  logic             iv_load,
  input  logic [31:0]      iv0,
  input  logic [31:0]      iv1,
  input  logic [31:0]      iv2,
  input  logic [31:0]      iv3,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      X0,
  output logic [31:0]      X1,
  output logic [31:0]      X2,
  output logic [31:0]      X3,
  input  logic [31:0]      Y0,
  input  logic [31:0]      Y1,
  input  logic [31:0]      Y2,
  input  logic [31:0]      Y3,
  input  logic             finish,
  input  logic             rki_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {WAIT_KEY, COLLECT, ISSUE, EMIT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic              key_ok_q;
  logic              dec_q, cbc_q;
  logic [0:3][31:0]  chain_q, x_q, ctb_q, out_q;
  logic [0:3][31:0]  y_w;
  logic [CNT_W-1:0]  blk_cnt_q;

  logic in_fire, out_fire, cur_dec, cur_cbc, iv_take;

  // Both streams transfer a word on a cycle where valid and ready are high
  // together; valid never waits on ready, and out_data is held while stalled.
  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == ISSUE) || (state_q == EMIT);
  assign in_fire   = in_ready && in_valid;
  assign out_fire  = out_valid && out_ready;

  // Mode is taken live for word 0 and from the latched copy afterwards.
  assign cur_dec = (idx_q == 2'd0) ? dec_en : dec_q;
  assign cur_cbc = (idx_q == 2'd0) ? cbc_en : cbc_q;
  assign iv_take = iv_load && ((state_q == WAIT_KEY) ||
                   ((state_q == COLLECT) && (idx_q == 2'd0) && !in_fire));

  assign y_w       = {Y0, Y1, Y2, Y3};
  assign X0        = x_q[0];
  assign X1        = x_q[1];
  assign X2        = x_q[2];
  assign X3        = x_q[3];
  assign out_data  = out_q[idx_q];
  assign blk_cnt   = blk_cnt_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      WAIT_KEY: if (key_ok_q) state_d = COLLECT;
      COLLECT: begin
        if (in_fire) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ISSUE;
        end
      end
      ISSUE: if (finish) state_d = EMIT;
      EMIT: begin
        if (out_fire) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = COLLECT;
        end
      end
      default: state_d = WAIT_KEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_KEY;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_ok_q  <= 1'b0;
      dec_q     <= 1'b0;
      cbc_q     <= 1'b0;
      chain_q   <= '0;
      x_q       <= '0;
      ctb_q     <= '0;
      out_q     <= '0;
      blk_cnt_q <= '0;
    end else begin
      if (rki_ready) key_ok_q <= 1'b1;
      if (iv_take) chain_q <= {iv0, iv1, iv2, iv3};
      if (in_fire) begin
        x_q[idx_q] <= (!cur_dec && cur_cbc) ? (in_data ^ chain_q[idx_q]) : in_data;
        if (cur_dec) ctb_q[idx_q] <= in_data;
        if (idx_q == 2'd0) begin
          dec_q <= dec_en;
          cbc_q <= cbc_en;
        end
      end
      if ((state_q == ISSUE) && finish) begin
        for (int k = 0; k < 4; k++) begin
          out_q[k] <= (dec_q && cbc_q) ? (y_w[k] ^ chain_q[k]) : y_w[k];
        end
        if (cbc_q) chain_q <= dec_q ? ctb_q : y_w;
      end
      if (out_fire && (idx_q == 2'd3)) blk_cnt_q <= blk_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sm4_block_if.sv
// Directed + randomized bench for sm4_block_if with a block-level chaining model
// and a stand-in core that answers known SM4 vectors and a fixed mix otherwise.
module tb_sm4_block_if;
  typedef logic [0:3][31:0] blk_t;

  localparam blk_t PT = {32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};
  localparam blk_t CT = {32'h681edf34, 32'hd206965e, 32'h86b3e94f, 32'h536e4246};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dec_en = 1'b0, cbc_en = 1'b0, iv_load = 1'b0;
  logic [31:0] iv0 = '0, iv1 = '0, iv2 = '0, iv3 = '0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] X0, X1, X2, X3;
  logic [31:0] Y0 = '0, Y1 = '0, Y2 = '0, Y3 = '0;
  logic        finish = 1'b0, rki_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [15:0] blk_cnt;
  logic [1:0]  dbg_state;

  int   checks = 0;
  int   errors = 0;
  blk_t mc = '0;
  int   model_cnt = 0;

  sm4_block_if #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .dec_en(dec_en), .cbc_en(cbc_en), .iv_load(iv_load),
    .iv0(iv0), .iv1(iv1), .iv2(iv2), .iv3(iv3),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .X0(X0), .X1(X1), .X2(X2), .X3(X3),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .finish(finish), .rki_ready(rki_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .blk_cnt(blk_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic blk_t core_f(input blk_t x, input logic dec);
    blk_t        y;
    logic [31:0] w;
    if (!dec && x == PT) return CT;
    if (dec && x == CT) return PT;
    for (int k = 0; k < 4; k++) begin
      w    = x[(k + 1) % 4];
      y[k] = {w[24:0], w[31:25]} ^ (dec ? 32'h5a5a5a5a : 32'h3c3c3c3c) ^ 32'(k);
    end
    return y;
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    for (int k = 0; k < 4; k++) b[k] = $urandom;
    return b;
  endfunction

  task automatic key_pulse();
    int n = 0;
    rki_ready = 1'b1;
    @(negedge clk);
    rki_ready = 1'b0;
    while (in_ready !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("key_to_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic load_iv(input blk_t v);
    {iv0, iv1, iv2, iv3} = v;
    iv_load = 1'b1;
    @(negedge clk);
    iv_load = 1'b0;
    mc = v;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_accept_timeout", 32'(n < 20), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    iv_load  = 1'b0;
  endtask

  task automatic run_block(input logic dec, input logic cbc, input blk_t pt,
                           input int hold0, input bit iv_mid, input bit iv_k0);
    blk_t xe, ye, oe;
    int   hold;
    for (int k = 0; k < 4; k++) xe[k] = (!dec && cbc) ? (pt[k] ^ mc[k]) : pt[k];
    ye = core_f(xe, dec);
    for (int k = 0; k < 4; k++) oe[k] = (dec && cbc) ? (ye[k] ^ mc[k]) : ye[k];
    if (cbc) mc = dec ? pt : ye;

    dec_en = dec;
    cbc_en = cbc;
    for (int k = 0; k < 4; k++) begin
      if (k == 0 && iv_k0) begin
        {iv0, iv1, iv2, iv3} = rand_blk();
        iv_load = 1'b1;
      end
      send_word(pt[k]);
      dec_en = 1'($urandom);
      cbc_en = 1'($urandom);
      if (k == 1 && iv_mid) begin
        {iv0, iv1, iv2, iv3} = rand_blk();
        iv_load = 1'b1;
        @(negedge clk);
        iv_load = 1'b0;
      end
    end

    chk("busy_in_issue", 32'(busy), 32'd1);
    chk("in_ready_issue", 32'(in_ready), 32'd0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    chk("x0", X0, xe[0]);
    chk("x1", X1, xe[1]);
    chk("x2", X2, xe[2]);
    chk("x3", X3, xe[3]);
    {Y0, Y1, Y2, Y3} = ye;
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    {Y0, Y1, Y2, Y3} = rand_blk();

    for (int k = 0; k < 4; k++) begin
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("out_word", out_data, oe[k]);
      hold = (k == 0) ? hold0 : $urandom_range(0, 2);
      repeat (hold) begin
        @(negedge clk);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_word", out_data, oe[k]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    model_cnt++;
    chk("out_valid_done", 32'(out_valid), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);
    chk("blk_cnt", 32'(blk_cnt), 32'(model_cnt));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_blk_cnt", 32'(blk_cnt), 32'd0);
    chk("rst_x0", X0, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Words offered before the key is ready must not be taken.
    in_data  = 32'hdeadbeef;
    in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("prekey_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    key_pulse();

    run_block(1'b0, 1'b0, PT, 0, 1'b0, 1'b0);

    load_iv('0);
    run_block(1'b0, 1'b1, PT, 5, 1'b0, 1'b0);
    run_block(1'b0, 1'b1, PT, 0, 1'b0, 1'b0);

    load_iv('0);
    run_block(1'b1, 1'b1, CT, 0, 1'b0, 1'b0);
    run_block(1'b1, 1'b1, rand_blk(), 1, 1'b0, 1'b0);

    load_iv(rand_blk());
    run_block(1'b0, 1'b1, rand_blk(), 0, 1'b1, 1'b0);
    run_block(1'b0, 1'b1, rand_blk(), 0, 1'b0, 1'b1);
    run_block(1'b1, 1'b1, rand_blk(), 0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) load_iv(rand_blk());
      if ($urandom_range(0, 2) == 0) begin
        {Y0, Y1, Y2, Y3} = rand_blk();
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
      end
      run_block(1'($urandom), 1'($urandom), rand_blk(), $urandom_range(0, 3),
                1'($urandom), 1'($urandom));
    end

    // Reset while the core holds a block.
    dec_en = 1'b0;
    cbc_en = 1'b0;
    for (int k = 0; k < 4; k++) send_word($urandom);
    chk("busy_before_rst", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_blk_cnt", 32'(blk_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mc = '0;
    model_cnt = 0;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rekey_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    key_pulse();
    run_block(1'b0, 1'b1, rand_blk(), 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
